// File: rtl/booth_mul_arbiter_pkg.sv
// Shared definitions for the two-requester Booth multiplier front end:
// FSM state encoding and default geometry.
package booth_mul_arbiter_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultTimeout = 40;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadM = 3'd1,
    StLoadQ = 3'd2,
    StBusy  = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered tie-break pointer.
// The pointer moves away from whichever requester was last served.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // Index of the requester that wins when both are asking.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    if (req_i[0] && (!req_i[1] || !prio_q)) begin
      gnt_o     = 2'b01;
      gnt_idx_o = 1'b0;
    end else if (req_i[1]) begin
      gnt_o     = 2'b10;
      gnt_idx_o = 1'b1;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (update_i) begin
      prio_d = ~served_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Arbitrates two requesters onto one sequential Booth multiplier: loads M then Q
// over a shared bus, waits for done (bounded by TIMEOUT) and returns the product.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     opa0,
  input  logic [WIDTH-1:0]     opb0,
  input  logic [WIDTH-1:0]     opa1,
  input  logic [WIDTH-1:0]     opb1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rsp_valid0,
  output logic                 rsp_valid1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_data,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 idx_q, idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_data_q, mul_data_d;
  logic                 rsp_valid0_q, rsp_valid0_d;
  logic                 rsp_valid1_q, rsp_valid1_d;

  logic                 grant_en;
  logic [1:0]           arb_gnt;
  logic                 arb_idx;
  logic                 arb_update;

  // Grants only from IDLE, and held quiet while reset is asserted.
  assign grant_en = (state_q == StIdle) && rst_n;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     ({req1, req0} & {2{grant_en}}),
    .update_i  (arb_update),
    .served_i  (idx_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign gnt0 = arb_gnt[0];
  assign gnt1 = arb_gnt[1];

  always_comb begin
    state_d      = state_q;
    opb_d        = opb_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    mul_start_d  = 1'b0;
    mul_data_d   = '0;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    arb_update   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          idx_d       = arb_idx;
          opb_d       = arb_idx ? opb1 : opb0;
          // mul_data_q doubles as the latched multiplicand for the LOAD_M cycle.
          mul_data_d  = arb_idx ? opa1 : opa0;
          mul_start_d = 1'b1;
          state_d     = StLoadM;
        end
      end
      StLoadM: begin
        mul_data_d = opb_q;
        state_d    = StLoadQ;
      end
      StLoadQ: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        if (mul_done) begin
          result_d     = mul_product;
          err_d        = 1'b0;
          rsp_valid0_d = ~idx_q;
          rsp_valid1_d = idx_q;
          state_d      = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          result_d     = '0;
          err_d        = 1'b1;
          rsp_valid0_d = ~idx_q;
          rsp_valid1_d = idx_q;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        arb_update = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opb_q        <= '0;
      idx_q        <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_data_q   <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opb_q        <= opb_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
      mul_start_q  <= mul_start_d;
      mul_data_q   <= mul_data_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
    end
  end

  assign result     = result_q;
  assign err        = err_q;
  assign mul_start  = mul_start_q;
  assign mul_data   = mul_data_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural Booth responder plus a response scoreboard.
module tb_booth_mul_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 40;
  localparam logic [2*W-1:0] Junk = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst_n;
  logic             req0, req1;
  logic [W-1:0]     opa0, opb0, opa1, opb1;
  logic             gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [2*W-1:0]   result;
  logic             err;
  logic             mul_start;
  logic [W-1:0]     mul_data;
  logic             mul_done;
  logic [2*W-1:0]   mul_product;

  logic             model_done;
  logic             stray_done;
  logic [2*W-1:0]   model_prod;
  int unsigned      model_lat;
  int unsigned      cyc;

  int n_checks;
  int n_errors;

  typedef struct {
    logic           idx;
    logic [2*W-1:0] res;
    logic           err;
    int unsigned    due;
  } exp_t;

  exp_t sb_q[$];
  logic gnt_log[$];

  assign mul_done    = model_done | stray_done;
  assign mul_product = model_done ? model_prod : Junk;

  booth_mul_arbiter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .req1        (req1),
    .opa0        (opa0),
    .opb0        (opb0),
    .opa1        (opa1),
    .opb1        (opb1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rsp_valid0  (rsp_valid0),
    .rsp_valid1  (rsp_valid1),
    .result      (result),
    .err         (err),
    .mul_start   (mul_start),
    .mul_data    (mul_data),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Booth multiplier stand-in: M on the mul_start cycle, Q on the next, done after model_lat.
  initial begin : mul_model
    logic [W-1:0] m, q;
    int unsigned  lat;
    bit           aborted;
    model_done = 1'b0;
    model_prod = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mul_start) begin
        m = mul_data;
        @(posedge clk); #1;
        q = mul_data;
        lat = model_lat;
        aborted = 1'b0;
        if (lat > 0) begin
          for (int i = 0; i < int'(lat); i++) begin
            @(posedge clk); #1;
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
          end
          if (!aborted) begin
            model_prod = smul(m, q);
            model_done = 1'b1;
            @(posedge clk); #1;
            model_done = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        e.idx = gnt1;
        if (model_lat == 0) begin
          e.res = '0;
          e.err = 1'b1;
          e.due = cyc + 3 + TO;
        end else begin
          e.res = gnt1 ? smul(opa1, opb1) : smul(opa0, opb0);
          e.err = 1'b0;
          e.due = cyc + 3 + model_lat;
        end
        sb_q.push_back(e);
        gnt_log.push_back(gnt1);
      end
      if (rsp_valid0 || rsp_valid1) begin
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", {rsp_valid1, rsp_valid0}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          check_eq("rsp_idx", {rsp_valid1, rsp_valid0}, e.idx ? 2'b10 : 2'b01);
          check_eq("rsp_result", result, e.res);
          check_eq("rsp_err", err, e.err);
          check_eq("rsp_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic wait_gnt(input logic idx, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = idx ? gnt1 : gnt0;
    end
    check_eq(tag, seen, 1'b1);
  endtask

  task automatic wait_rsp(input logic idx, input bit any, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = any ? (rsp_valid0 | rsp_valid1) : (idx ? rsp_valid1 : rsp_valid0);
    end
    check_eq(tag, seen, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req0 = 1'b1;
    req1 = 1'b0;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    stray_done = 1'b0;
    model_lat = 17;

    // Reset values, with req0 already high to show grants stay quiet in reset.
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {gnt0, gnt1, rsp_valid0, rsp_valid1, mul_start, err}, 6'b0);
    check_eq("rst_mul_data", mul_data, 16'h0);
    check_eq("rst_result", result, 32'h0);

    // Single operation from requester 0.
    @(posedge clk); #1;
    opa0 = 16'h8006;
    opb0 = 16'h000D;
    rst_n = 1'b1;
    wait_gnt(1'b0, "r029_gnt0");
    check_eq("r029_gnt1_low", gnt1, 1'b0);
    @(negedge clk);
    check_eq("r029_load_m", {mul_start, mul_data}, {1'b1, 16'h8006});
    @(negedge clk);
    check_eq("r029_load_q", {mul_start, mul_data}, {1'b0, 16'h000D});
    @(negedge clk);
    check_eq("r029_busy_bus", {mul_start, mul_data}, 17'h0);
    wait_rsp(1'b0, 1'b0, "r029_rsp0");
    check_eq("r029_result", result, 32'hFFF9_804E);
    check_eq("r029_err", err, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;

    // Stray mul_done while idle.
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(negedge clk);
    check_eq("idle_stray_ctrl", {mul_start, rsp_valid0, rsp_valid1, gnt0, gnt1}, 5'b0);
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_stray_hold", {err, result}, {1'b0, 32'hFFF9_804E});

    // Pointer reset, then continuous contention alternates 0,1,0,1.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gnt_log.delete();
    model_lat = 5;
    opa0 = 16'h0007; opb0 = 16'hFFFF;
    opa1 = 16'h1234; opb1 = 16'h0010;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (4) wait_rsp(1'b0, 1'b1, "r030_rsp");
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    check_eq("r030_count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
      check_eq($sformatf("r030_order_%0d", k), gnt_log[k], k[0]);
    end

    // Multiplier never answers: timeout response, then a normal one.
    model_lat = 0;
    opa0 = 16'h0101; opb0 = 16'h0202;
    req0 = 1'b1;
    wait_gnt(1'b0, "r031_gnt0");
    wait_rsp(1'b0, 1'b0, "r031_rsp0");
    check_eq("r031_timeout", {err, result}, {1'b1, 32'h0});
    @(posedge clk); #1;
    req0 = 1'b0;
    model_lat = 4;
    opa1 = 16'hFFFF; opb1 = 16'hFFFF;
    req1 = 1'b1;
    wait_gnt(1'b1, "r031_gnt1");
    wait_rsp(1'b1, 1'b0, "r031_rsp1");
    check_eq("r031_after", {err, result}, {1'b0, 32'h1});
    @(posedge clk); #1;
    req1 = 1'b0;

    // Stray mul_done in LOAD_Q and req1 dropped mid-operation.
    model_lat = 17;
    opa1 = 16'h0003; opb1 = 16'hFFFE;
    req1 = 1'b1;
    wait_gnt(1'b1, "r033_gnt1");
    @(posedge clk); #1;
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(negedge clk);
    check_eq("r033_load_q", {mul_start, mul_data}, {1'b0, 16'hFFFE});
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    req1 = 1'b0;
    wait_rsp(1'b1, 1'b0, "r033_rsp1");
    check_eq("r033_result", {err, result}, {1'b0, 32'hFFFF_FFFA});

    // Reset in the middle of BUSY discards the operation.
    opa0 = 16'h0100; opb0 = 16'h0100;
    req0 = 1'b1;
    wait_gnt(1'b0, "r032_gnt0");
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check_eq("r032_rst_ctrl", {gnt0, gnt1, rsp_valid0, rsp_valid1, mul_start, err}, 6'b0);
    check_eq("r032_rst_bus", mul_data, 16'h0);
    check_eq("r032_rst_result", result, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_lat = 3;
    opa1 = 16'h0002; opb1 = 16'h0005;
    req1 = 1'b1;
    wait_gnt(1'b1, "r032_gnt1");
    wait_rsp(1'b1, 1'b0, "r032_rsp1");
    check_eq("r032_result", result, 32'h0000_000A);
    @(posedge clk); #1;
    req1 = 1'b0;

    repeat (5) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand width; the product SHALL be 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 40, SHALL set the maximum cycles spent waiting for mul_done.
REQ-003 The clock port SHALL be: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 The reset port SHALL be: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Requester ports SHALL be: req0/req1  in  1  operation request, held until the matching rsp_valid.
REQ-006 Operand ports SHALL be: opa0/opa1  in  WIDTH  multiplicand M; opb0/opb1  in  WIDTH  multiplier Q; each sampled at grant.
REQ-007 Grant ports SHALL be: gnt0/gnt1  out  1  one-cycle pulse when that requester's operands are captured.
REQ-008 Response ports SHALL be: rsp_valid0/rsp_valid1  out  1  one-cycle result pulse; result  out  2*WIDTH  product; err  out  1  timeout flag, valid with rsp_valid.
REQ-009 Multiplier-side ports SHALL be: mul_start  out  1; mul_data  out  WIDTH  shared M/Q load bus; mul_done  in  1; mul_product  in  2*WIDTH  {A,Q} of the Booth datapath.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD_M, LOAD_Q, BUSY, RESP.
REQ-011 In IDLE with any req asserted, the block SHALL pulse the winner's gnt, latch its opa/opb and its index into registers, and go to LOAD_M on the next edge.
REQ-012 Arbitration SHALL be round-robin: with both req asserted, the requester not served last SHALL win; after reset, requester 0 SHALL win a tie.
REQ-013 LOAD_M SHALL last exactly one cycle, drive mul_start=1 and mul_data=latched opa, then go to LOAD_Q.
REQ-014 LOAD_Q SHALL last exactly one cycle, drive mul_start=0 and mul_data=latched opb, then go to BUSY.
REQ-015 In every state other than LOAD_M and LOAD_Q, mul_data SHALL be 0 and mul_start SHALL be 0.
REQ-016 BUSY SHALL count cycles from 0; on mul_done=1 it SHALL latch mul_product into result, clear err, and go to RESP.
REQ-017 If the BUSY count reaches TIMEOUT-1 without mul_done, the block SHALL set err=1, set result=0, and go to RESP.
REQ-018 If mul_done and the timeout coincide, mul_done SHALL take priority (err=0).
REQ-019 RESP SHALL pulse rsp_valid of the latched requester for exactly one cycle, update the round-robin pointer, and return to IDLE.
REQ-020 result and err SHALL hold their values until the next RESP.
REQ-021 Grant-to-rsp_valid latency SHALL be 3 + (BUSY cycles); a new grant SHALL be possible in the cycle after RESP, giving no back-to-back grants.
REQ-022 A req deasserted after grant SHALL NOT abort the operation; its rsp_valid still pulses.
REQ-023 mul_done in any state other than BUSY SHALL be ignored.

Reset
REQ-024 On rst_n=0, the FSM SHALL asynchronously enter IDLE, and gnt*, rsp_valid*, mul_start, mul_data, result, err, the counter, and the latched index SHALL be 0.
REQ-025 On rst_n=0, the round-robin pointer SHALL be set so requester 0 wins next.
REQ-026 A reset mid-operation SHALL discard the operation with no rsp_valid; after release, requesters re-request.

Structure
REQ-027 State encodings (3-bit), the default WIDTH and the default TIMEOUT SHALL live in the shared booth package.
REQ-028 A sub-module rr_arb2 (2-way round-robin, combinational grant plus pointer register) is natural; everything else SHALL be in one module.

Verification
REQ-029 Reset then req0 with opa0=16'h8006, opb0=16'h000D, against a behavioural Booth model answering in 17 cycles -> gnt0 at cycle 1, mul_data 8006 then 000D, rsp_valid0 with result=32'hFFF9804E, err=0.
REQ-030 req0 and req1 asserted together, held continuously -> grants alternate 0,1,0,1 over four operations.
REQ-031 Model never asserts mul_done, TIMEOUT=40 -> rsp_valid after exactly 40 BUSY cycles, err=1, result=0, next request served normally.
REQ-032 rst_n pulsed low during BUSY -> all outputs 0 immediately, no rsp_valid, fresh req1 granted after release.
REQ-033 Spurious mul_done in IDLE and LOAD_Q, and req1 dropped mid-BUSY -> no state change from the stray mul_done; rsp_valid1 still delivered with the correct product (opa=16'h0003, opb=16'hFFFE -> 32'hFFFFFFFA).
